// File: rtl/key_code_pkg.sv
// key_code_pkg
// Shared definitions for the keypad code encoder:
//   - KEY_W / CODE_W : keypad width and width of the encoded key index
//   - key_state_t    : states of the scan/debounce state machine
//   - onehot_to_index: one-hot keypad lines to key index (no priority)
//   - popcount_gt1   : high when more than one keypad line is set
package key_code_pkg;

  localparam int KEY_W  = 16;
  localparam int CODE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    VALID,
    RELEASE,
    ERROR
  } key_state_t;

  // OR together the indices of every set bit. For a one-hot input this is
  // exactly the index of that bit, and no bit takes priority over another.
  function automatic logic [CODE_W-1:0] onehot_to_index(input logic [KEY_W-1:0] onehot);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (onehot[i]) begin
        idx = idx | CODE_W'(i);
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something behind only when at least
  // two bits were set.
  function automatic logic popcount_gt1(input logic [KEY_W-1:0] value);
    return (value & (value - KEY_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/key_stable_counter.sv
// key_stable_counter
// Counts consecutive enabled cycles toward DEBOUNCE_CYCLES. Used both to
// qualify a press and to qualify a release.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous reset, active-low
//   clear  : restart the count at zero on the next edge
//   enable : advance the count by one on the next edge (ignored under clear)
//   done   : the count has reached DEBOUNCE_CYCLES-1
module key_stable_counter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The count saturates at LAST so it can never wrap, whatever the caller does.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/key_code_encoder.sv
// key_code_encoder
// Scans a 16-line one-hot keypad, debounces presses and releases, and
// presents the pressed key index as a 4-bit code for the display block.
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous reset, active-low
//   keys[15:0] : raw keypad lines, keys[i]=1 while key i is pressed
//   a,b,c,d    : key index, a is the MSB and d the LSB
//   ready      : a/b/c/d hold a debounced, valid key code
//   error      : more than one key was pressed from idle
// All outputs come straight from registers.
module key_code_encoder
  import key_code_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] keys,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             ready,
  output logic             error
);

  key_state_t        state_q, state_d;
  logic [KEY_W-1:0]  snap_q, snap_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_done;

  key_stable_counter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_stable_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .done  (cnt_done)
  );

  // The counter is cleared on every cycle unless it is actively qualifying a
  // stable press or a stable release, so each state starts counting from zero.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    code_d     = code_q;
    ready_d    = ready_q;
    error_d    = error_q;
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (keys != '0) begin
          if (popcount_gt1(keys)) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            state_d = DEBOUNCE;
            snap_d  = keys;
          end
        end
      end

      DEBOUNCE: begin
        if (keys != snap_q) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          state_d = VALID;
          code_d  = onehot_to_index(snap_q);
          ready_d = 1'b1;
        end else begin
          cnt_clear  = 1'b0;
          cnt_enable = 1'b1;
        end
      end

      // Any departure from the latched key, including an added key, is a
      // release; the code stays visible until the release settles.
      VALID: begin
        if (keys != snap_q) begin
          state_d = RELEASE;
          ready_d = 1'b0;
        end
      end

      RELEASE: begin
        if (keys == '0) begin
          if (cnt_done) begin
            state_d = IDLE;
            code_d  = '0;
          end else begin
            cnt_clear  = 1'b0;
            cnt_enable = 1'b1;
          end
        end
      end

      ERROR: begin
        if (keys == '0) begin
          state_d = IDLE;
          error_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        code_d  = '0;
        ready_d = 1'b0;
        error_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over every state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      code_q  <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      code_q  <= code_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign a     = code_q[3];
  assign b     = code_q[2];
  assign c     = code_q[1];
  assign d     = code_q[0];
  assign ready = ready_q;
  assign error = error_q;

endmodule

// File: tb/tb_key_code_encoder.sv
// tb_key_code_encoder
// Self-checking bench for key_code_encoder with DEBOUNCE_CYCLES=4.
// A behavioural model is stepped on every rising edge and compared with the
// DUT shortly after; directed scenarios add literal expectations, then a
// randomized keypad sequence exercises the rest.
module tb_key_code_encoder;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys;
  logic        a, b, c, d, ready, error;

  int check_count = 0;
  int pass_count  = 0;

  key_code_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .keys (keys),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .ready(ready),
    .error(error)
  );

  always #5 clk = ~clk;

  // Behavioural model: tracks what the user is doing (waiting, holding a
  // candidate key, showing a code, letting go, mashing several keys) and how
  // many consecutive edges the relevant condition has held.
  localparam int M_WAIT  = 0;
  localparam int M_QUAL  = 1;
  localparam int M_HELD  = 2;
  localparam int M_DRAIN = 3;
  localparam int M_FAULT = 4;

  int          m_mode  = M_WAIT;
  logic [15:0] m_pat   = '0;
  int          m_run   = 0;
  logic [3:0]  m_code  = '0;
  logic        m_ready = 1'b0;
  logic        m_error = 1'b0;

  function automatic logic [3:0] key_index(input logic [15:0] k);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic void model_step(input logic [15:0] k, input logic rst_n);
    if (!rst_n) begin
      m_mode  = M_WAIT;
      m_pat   = '0;
      m_run   = 0;
      m_code  = '0;
      m_ready = 1'b0;
      m_error = 1'b0;
      return;
    end
    case (m_mode)
      M_WAIT: begin
        if ($countones(k) == 1) begin
          m_pat  = k;
          m_run  = 0;
          m_mode = M_QUAL;
        end else if ($countones(k) > 1) begin
          m_error = 1'b1;
          m_mode  = M_FAULT;
        end
      end
      M_QUAL: begin
        if (k != m_pat) begin
          m_mode = M_WAIT;
        end else begin
          m_run = m_run + 1;
          if (m_run == DEB) begin
            m_code  = key_index(m_pat);
            m_ready = 1'b1;
            m_mode  = M_HELD;
          end
        end
      end
      M_HELD: begin
        if (k != m_pat) begin
          m_ready = 1'b0;
          m_run   = 0;
          m_mode  = M_DRAIN;
        end
      end
      M_DRAIN: begin
        if (k != 0) begin
          m_run = 0;
        end else begin
          m_run = m_run + 1;
          if (m_run == DEB) begin
            m_code = '0;
            m_mode = M_WAIT;
          end
        end
      end
      default: begin
        if (k == 0) begin
          m_error = 1'b0;
          m_mode  = M_WAIT;
        end
      end
    endcase
  endfunction

  // Compare process: step the model with the values the DUT sees at each
  // edge, then compare once the DUT registers have settled.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      model_step(keys, reset);
      #1;
      cyc++;
      check_count++;
      if ({a, b, c, d, ready, error} === {m_code, m_ready, m_error}) begin
        pass_count++;
      end else begin
        $display("[TB] FAIL model_cycle_%0d: got code=%h ready=%b error=%b, expected code=%h ready=%b error=%b",
                 cyc, {a, b, c, d}, ready, error, m_code, m_ready, m_error);
      end
    end
  end

  // Drive keys for n rising edges; returns at a falling edge with the
  // outputs of the last edge visible.
  task automatic applyStimulus(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      keys = k;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_code,
                             input logic exp_ready, input logic exp_error);
    check_count++;
    if ({a, b, c, d, ready, error} === {exp_code, exp_ready, exp_error}) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got code=%h ready=%b error=%b, expected code=%h ready=%b error=%b",
               name, {a, b, c, d}, ready, error, exp_code, exp_ready, exp_error);
    end
  endtask

  initial begin
    int          sel;
    int          len;
    logic [15:0] one;
    logic [15:0] k;

    // Reset held for two edges with a key down.
    reset = 1'b0;
    keys  = 16'h0040;
    applyStimulus(16'h0040, 2);
    checkOutput("reset_hold", 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(16'h0040, 4);
    checkOutput("post_reset_debouncing", 4'h0, 1'b0, 1'b0);
    applyStimulus(16'h0040, 1);
    checkOutput("post_reset_key6", 4'h6, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1);
    checkOutput("key6_release_edge", 4'h6, 1'b0, 1'b0);
    applyStimulus(16'h0000, 3);
    checkOutput("key6_release_hold", 4'h6, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1);
    checkOutput("key6_release_done", 4'h0, 1'b0, 1'b0);

    // Clean press of key 9.
    applyStimulus(16'h0200, 4);
    checkOutput("press9_edge_k3", 4'h0, 1'b0, 1'b0);
    applyStimulus(16'h0200, 1);
    checkOutput("press9_edge_k4", 4'h9, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1);
    checkOutput("press9_release", 4'h9, 1'b0, 1'b0);
    applyStimulus(16'h0000, 4);
    checkOutput("press9_cleared", 4'h0, 1'b0, 1'b0);

    // Bouncing key 3.
    applyStimulus(16'h0008, 2);
    applyStimulus(16'h0000, 1);
    applyStimulus(16'h0008, 4);
    checkOutput("bounce_not_yet", 4'h0, 1'b0, 1'b0);
    applyStimulus(16'h0008, 1);
    checkOutput("bounce_key3", 4'h3, 1'b1, 1'b0);
    applyStimulus(16'h0000, 5);
    checkOutput("bounce_cleared", 4'h0, 1'b0, 1'b0);

    // Two keys at once.
    applyStimulus(16'h8001, 1);
    checkOutput("multi_error", 4'h0, 1'b0, 1'b1);
    applyStimulus(16'h8001, 2);
    checkOutput("multi_held", 4'h0, 1'b0, 1'b1);
    applyStimulus(16'h0000, 1);
    checkOutput("multi_cleared", 4'h0, 1'b0, 1'b0);

    // Key changes while a code is shown.
    applyStimulus(16'h0020, 5);
    checkOutput("change_key5", 4'h5, 1'b1, 1'b0);
    applyStimulus(16'h0040, 1);
    checkOutput("change_drop", 4'h5, 1'b0, 1'b0);
    applyStimulus(16'h0040, 6);
    checkOutput("change_no_new_code", 4'h5, 1'b0, 1'b0);
    applyStimulus(16'h0000, 4);
    checkOutput("change_cleared", 4'h0, 1'b0, 1'b0);
    applyStimulus(16'h0040, 5);
    checkOutput("change_key6", 4'h6, 1'b1, 1'b0);
    applyStimulus(16'h0000, 5);

    // Reset during debounce and during a shown code.
    applyStimulus(16'h0004, 2);
    reset = 1'b0;
    applyStimulus(16'h0004, 1);
    checkOutput("reset_mid_debounce", 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(16'h0004, 4);
    checkOutput("redebounce_1", 4'h0, 1'b0, 1'b0);
    applyStimulus(16'h0004, 1);
    checkOutput("redebounce_1_done", 4'h2, 1'b1, 1'b0);
    reset = 1'b0;
    applyStimulus(16'h0004, 1);
    checkOutput("reset_mid_valid", 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(16'h0004, 4);
    checkOutput("redebounce_2", 4'h0, 1'b0, 1'b0);
    applyStimulus(16'h0004, 1);
    checkOutput("redebounce_2_done", 4'h2, 1'b1, 1'b0);
    applyStimulus(16'h0000, 5);

    // Randomized keypad activity, checked by the model every edge.
    one = 16'h0001;
    k   = '0;
    for (int s = 0; s < 300; s++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 10);
      if (sel <= 2) begin
        k = '0;
      end else if (sel <= 6) begin
        k = one << $urandom_range(0, 15);
      end else if (sel == 7) begin
        k = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
      end
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        applyStimulus(k, 1);
        reset = 1'b1;
      end
      applyStimulus(k, len);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/key_code_encoder.md
Name: key_code_encoder

Overview:
- Transmit end of the 4-bit code interface that feeds the Display block. Display consumes the code bits a, b, c, d and the ready flag, and renders the code on two 7-segment digits (dse, dsd).
- This block scans a 16-key one-hot keypad, debounces the press and encodes the key index into a/b/c/d. It raises ready while the code is valid and drops it on release.
- Multiple simultaneous keys are flagged as an error and never produce a code.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive clock cycles keys must stay unchanged before a press or release is accepted. Legal range is 1 to 255.
- CNT_W, 8: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset).
- keys  input  16  raw keypad lines; keys[i]=1 means key i is pressed.
- a  output  1  code bit 3 (MSB) of the key index.
- b  output  1  code bit 2.
- c  output  1  code bit 1.
- d  output  1  code bit 0 (LSB).
- ready  output  1  high while a/b/c/d hold a debounced, valid key code.
- error  output  1  high while more than one key is held.

Behaviour:
- Reset: one clock, synchronous, active-low. When reset=0 at a rising edge:
  - state goes to IDLE;
  - a=b=c=d=0, ready=0, error=0;
  - the debounce counter is 0 and the latched keys are 0.
  - reset overrides every other condition, including mid-debounce and VALID.
- All outputs are registered; nothing is combinational from keys.
- IDLE:
  - keys==0: stay in IDLE.
  - exactly one bit set: latch keys into snap, set cnt=0, go to DEBOUNCE.
  - two or more bits set: go to ERROR.
- DEBOUNCE:
  - keys != snap: go to IDLE, outputs unchanged (ready stays 0).
  - keys == snap and cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - keys == snap and cnt == DEBOUNCE_CYCLES-1: go to VALID; {a,b,c,d} = index of the set bit in snap; ready=1.
  - Latency: if a single key is applied before edge k, ready=1 is visible after edge k+DEBOUNCE_CYCLES.
- VALID:
  - a/b/c/d and ready are held.
  - keys == snap: stay.
  - any other value (release, added key, changed key): ready=0 on that edge; set cnt=0; go to RELEASE.
  - a/b/c/d keep the last code until IDLE is re-entered.
- RELEASE:
  - keys != 0: set cnt=0 and stay.
  - keys == 0 for DEBOUNCE_CYCLES consecutive edges: go to IDLE and clear a/b/c/d to 0.
  - A new press is only accepted after IDLE is reached; there is no direct RELEASE-to-DEBOUNCE path.
- ERROR:
  - error=1 on the entry edge; ready stays 0.
  - stay while keys != 0.
  - keys == 0: error=0, go to IDLE.
- Encoding: index 0..15 is mapped by a priority-free one-hot decode. Multi-hot input is excluded by the state machine, so the decode never sees it.
- DEBOUNCE_CYCLES=1: VALID is entered on the first edge after DEBOUNCE is entered, with the same comparison rules.
- Counter: cnt never wraps. It is bounded by DEBOUNCE_CYCLES-1 and cleared on every state entry.

Decomposition:
- Shared package key_code_pkg holds:
  - the state enum {IDLE, DEBOUNCE, VALID, RELEASE, ERROR};
  - the constants KEY_W=16 and CODE_W=4;
  - the function onehot_to_index (16 bits to 4 bits);
  - the function popcount_gt1 (16 bits to 1 bit).
- One sub-module is natural: key_stable_counter. It takes clk, reset, a clear input and an enable input, and produces a done output. It holds the debounce count and is reused by the DEBOUNCE and RELEASE states.
- The FSM and the output registers stay in key_code_encoder.

Test Plan:
- Reset: hold reset=0 for 2 cycles with keys=16'h0040. Expect a,b,c,d=0, ready=0, error=0 and state IDLE; these must remain after reset=1 until debounce completes.
- Clean press: with DEBOUNCE_CYCLES=4, apply keys=16'h0200 before edge k. Expect ready=1 with {a,b,c,d}=4'b1001 after edge k+4. Release to 0; ready=0 next edge and {a,b,c,d} returns to 0 four edges later.
- Bounce: apply keys=16'h0008 for 2 cycles, then 0 for 1 cycle, then 16'h0008 again. Ready must stay 0 until 4 stable cycles after the final change, then {a,b,c,d}=4'b0011.
- Multi-key: apply keys=16'h8001. Expect error=1 one edge later and ready=0 throughout; keys=0 clears error on the next edge.
- Change while VALID: key 5 is VALID ({a,b,c,d}=0101), then keys changes to 16'h0040 without a release. Ready=0 next edge; no new code is produced until keys=0 for 4 edges and a fresh press of key 6 gives 0110.
- Reset mid-operation: pull reset=0 for one edge during DEBOUNCE and again during VALID. All outputs must be 0 on that edge, and the bench must confirm a full new debounce is required afterwards.
